// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core; owns the memory handshake.
// Optional retired-instruction counter (o_instret) when MC_INSTRET_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15  // 1..255
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic       i_mem_ready,
  input  logic       i_br_taken,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic [1:0] o_pc_sel,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_mem_addr_sel,
  output logic       o_rf_we,
  output logic [1:0] o_wb_sel,
  output logic       o_alu_a_sel,
  output logic       o_alu_b_sel,
  output logic [1:0] o_alu_op,
  output logic [2:0] o_imm_sel,
  output logic       o_trap,
  output logic [1:0] o_trap_cause,
  output logic [2:0] o_state
`ifdef MC_INSTRET_EN
  ,
  output logic [31:0] o_instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } cls_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state_q, state_d;
  cls_t       cls;
  logic [7:0] wait_q;
  logic       trap_q;
  logic [1:0] cause_q, cause_d;
  logic       mem_phase, timeout;

  logic       a_sel, b_sel;
  logic [1:0] alu_op, wb_sel, jmp_sel;
  logic [2:0] imm_sel;

  always_comb begin
    case (i_opcode)
      7'b0110011: cls = C_R;
      7'b0010011: cls = C_IALU;
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b1100011: cls = C_BR;
      7'b1101111: cls = C_JAL;
      7'b1100111: cls = C_JALR;
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      default:    cls = C_ILL;
    endcase
  end

  // Datapath setup per class; held through MEM/WB so address, jump target and imm stay valid.
  always_comb begin
    a_sel = 1'b0; b_sel = 1'b0; alu_op = 2'd0; imm_sel = 3'd0;
    wb_sel = 2'd0; jmp_sel = 2'd0;
    case (cls)
      C_R:     alu_op = 2'd2;
      C_IALU:  begin b_sel = 1'b1; alu_op = 2'd2; end
      C_LOAD:  begin b_sel = 1'b1; wb_sel = 2'd1; end
      C_STORE: begin b_sel = 1'b1; imm_sel = 3'd1; end
      C_BR:    begin alu_op = 2'd1; imm_sel = 3'd2; end
      C_AUIPC: begin a_sel = 1'b1; b_sel = 1'b1; imm_sel = 3'd3; end
      C_LUI:   begin imm_sel = 3'd3; wb_sel = 2'd3; end
      C_JAL:   begin imm_sel = 3'd4; wb_sel = 2'd2; jmp_sel = 2'd1; end
      C_JALR:  begin b_sel = 1'b1; wb_sel = 2'd2; jmp_sel = 2'd2; end
      default: ;
    endcase
  end

  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  // Ready in the last tolerated cycle still completes the request.
  assign timeout   = mem_phase && !i_mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    state_d        = state_q;
    cause_d        = 2'd0;
    o_ir_we        = 1'b0;
    o_pc_we        = 1'b0;
    o_pc_sel       = 2'd0;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr_sel = 1'b0;
    o_rf_we        = 1'b0;
    o_wb_sel       = 2'd0;
    o_alu_a_sel    = 1'b0;
    o_alu_b_sel    = 1'b0;
    o_alu_op       = 2'd0;
    o_imm_sel      = 3'd0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      o_alu_a_sel = a_sel;
      o_alu_b_sel = b_sel;
      o_alu_op    = alu_op;
      o_imm_sel   = imm_sel;
    end
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          o_mem_req = 1'b1;
          if (i_mem_ready) begin
            o_ir_we = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls == C_BR) begin
          o_pc_we  = 1'b1;
          o_pc_sel = {1'b0, i_br_taken};
          state_d  = S_FETCH;
        end else if (cls == C_LOAD || cls == C_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (timeout) begin
          // Side effects (selects included) dropped in the timeout cycle.
          state_d     = S_TRAP;
          cause_d     = 2'd2;
          o_alu_a_sel = 1'b0;
          o_alu_b_sel = 1'b0;
          o_alu_op    = 2'd0;
          o_imm_sel   = 3'd0;
        end else begin
          o_mem_req      = 1'b1;
          o_mem_addr_sel = 1'b1;
          o_mem_we       = (cls == C_STORE);
          if (i_mem_ready) begin
            if (cls == C_STORE) begin
              o_pc_we = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
      end
      S_WB: begin
        o_rf_we  = 1'b1;
        o_pc_we  = 1'b1;
        o_wb_sel = wb_sel;
        o_pc_sel = jmp_sel;
        state_d  = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
      trap_q  <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)            wait_q <= 8'd0;
      else if (mem_phase && !i_mem_ready) wait_q <= wait_q + 8'd1;
      if (state_d == S_TRAP && state_q != S_TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
    end
  end

  assign o_trap       = trap_q;
  assign o_trap_cause = cause_q;
  assign o_state      = state_q;

`ifdef MC_INSTRET_EN
  logic [31:0] instret_q;
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst)       instret_q <= 32'd0;
    else if (o_pc_we) instret_q <= instret_q + 32'd1;
  end
  assign o_instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (WAIT_MAX=4); checks o_instret when MC_INSTRET_EN is defined.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [6:0] i_opcode;
  logic       i_mem_ready, i_br_taken;
  logic       o_ir_we, o_pc_we, o_mem_req, o_mem_we, o_mem_addr_sel, o_rf_we;
  logic       o_alu_a_sel, o_alu_b_sel, o_trap;
  logic [1:0] o_pc_sel, o_wb_sel, o_alu_op, o_trap_cause;
  logic [2:0] o_imm_sel, o_state;
`ifdef MC_INSTRET_EN
  logic [31:0] o_instret;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_MAX(4)) dut (
    .clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
    .i_br_taken(i_br_taken), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr_sel(o_mem_addr_sel),
    .o_rf_we(o_rf_we), .o_wb_sel(o_wb_sel), .o_alu_a_sel(o_alu_a_sel),
    .o_alu_b_sel(o_alu_b_sel), .o_alu_op(o_alu_op), .o_imm_sel(o_imm_sel),
    .o_trap(o_trap), .o_trap_cause(o_trap_cause), .o_state(o_state)
`ifdef MC_INSTRET_EN
    , .o_instret(o_instret)
`endif
  );

  logic [16:0] ctl_now;
  assign ctl_now = {o_ir_we, o_pc_we, o_pc_sel, o_mem_req, o_mem_we, o_mem_addr_sel,
                    o_rf_we, o_wb_sel, o_alu_a_sel, o_alu_b_sel, o_alu_op, o_imm_sel};

  function automatic logic [16:0] mk(input logic ir, input logic pw, input logic [1:0] ps,
                                     input logic rq, input logic we, input logic as,
                                     input logic rf, input logic [1:0] wb, input logic a,
                                     input logic b, input logic [1:0] op, input logic [2:0] im);
    return {ir, pw, ps, rq, we, as, rf, wb, a, b, op, im};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: apply inputs, check state/controls, advance one clock.
  task automatic cyc(input string tag, input logic rdy, input logic br,
                     input logic [2:0] st, input logic [16:0] exp);
    i_mem_ready = rdy;
    i_br_taken  = br;
    #1;
    chk({tag, ".st"}, 32'(o_state), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl_now), 32'(exp));
    @(negedge clk);
  endtask

  logic [16:0] f_rdy, f_wait;

  initial begin
    f_rdy  = mk(1,0,0,1,0,0,0,0,0,0,0,0);
    f_wait = mk(0,0,0,1,0,0,0,0,0,0,0,0);
    i_rst = 1'b0; i_opcode = 7'b0110011; i_mem_ready = 1'b0; i_br_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.st", 32'(o_state), 0);
    chk("rst.ctl", 32'(ctl_now), 0);
    chk("rst.trap", 32'({o_trap, o_trap_cause}), 0);
`ifdef MC_INSTRET_EN
    chk("rst.instret", o_instret, 0);
`endif
    i_rst = 1'b1;
    cyc("idle", 1, 0, 0, 0);

    // R-type, zero wait
    cyc("r.f", 1, 0, 1, f_rdy);
    cyc("r.d", 0, 0, 2, 0);
    cyc("r.e", 1, 0, 3, mk(0,0,0,0,0,0,0,0,0,0,2,0));
    cyc("r.w", 0, 0, 5, mk(0,1,0,0,0,0,1,0,0,0,2,0));

    // Load, 3 wait cycles in MEM (ready lands on the last tolerated cycle)
    i_opcode = 7'b0000011;
    cyc("ld.f", 1, 0, 1, f_rdy);
    cyc("ld.d", 1, 0, 2, 0);
    cyc("ld.e", 1, 0, 3, mk(0,0,0,0,0,0,0,0,0,1,0,0));
    for (int i = 0; i < 3; i++) cyc("ld.mw", 0, 0, 4, mk(0,0,0,1,0,1,0,0,0,1,0,0));
    cyc("ld.m", 1, 0, 4, mk(0,0,0,1,0,1,0,0,0,1,0,0));
    cyc("ld.w", 0, 0, 5, mk(0,1,0,0,0,0,1,1,0,1,0,0));

    // Store, zero wait
    i_opcode = 7'b0100011;
    cyc("st.f", 1, 0, 1, f_rdy);
    cyc("st.d", 0, 0, 2, 0);
    cyc("st.e", 0, 0, 3, mk(0,0,0,0,0,0,0,0,0,1,0,1));
    cyc("st.m", 1, 0, 4, mk(0,1,0,1,1,1,0,0,0,1,0,1));
`ifdef MC_INSTRET_EN
    #1 chk("instret3", o_instret, 3);
`endif

    // Branch taken, then not taken
    i_opcode = 7'b1100011;
    cyc("bt.f", 1, 0, 1, f_rdy);
    cyc("bt.d", 0, 1, 2, 0);
    cyc("bt.e", 0, 1, 3, mk(0,1,1,0,0,0,0,0,0,0,1,2));
    cyc("bn.f", 1, 0, 1, f_rdy);
    cyc("bn.d", 0, 0, 2, 0);
    cyc("bn.e", 0, 0, 3, mk(0,1,0,0,0,0,0,0,0,0,1,2));

    // JAL
    i_opcode = 7'b1101111;
    cyc("jal.f", 1, 0, 1, f_rdy);
    cyc("jal.d", 0, 0, 2, 0);
    cyc("jal.e", 0, 0, 3, mk(0,0,0,0,0,0,0,0,0,0,0,4));
    cyc("jal.w", 0, 0, 5, mk(0,1,1,0,0,0,1,2,0,0,0,4));

    // JALR
    i_opcode = 7'b1100111;
    cyc("jalr.f", 1, 0, 1, f_rdy);
    cyc("jalr.d", 0, 0, 2, 0);
    cyc("jalr.e", 0, 0, 3, mk(0,0,0,0,0,0,0,0,0,1,0,0));
    cyc("jalr.w", 0, 0, 5, mk(0,1,2,0,0,0,1,2,0,1,0,0));

    // LUI
    i_opcode = 7'b0110111;
    cyc("lui.f", 1, 0, 1, f_rdy);
    cyc("lui.d", 0, 0, 2, 0);
    cyc("lui.e", 0, 0, 3, mk(0,0,0,0,0,0,0,0,0,0,0,3));
    cyc("lui.w", 0, 0, 5, mk(0,1,0,0,0,0,1,3,0,0,0,3));

    // AUIPC
    i_opcode = 7'b0010111;
    cyc("aui.f", 1, 0, 1, f_rdy);
    cyc("aui.d", 0, 0, 2, 0);
    cyc("aui.e", 0, 0, 3, mk(0,0,0,0,0,0,0,0,1,1,0,3));
    cyc("aui.w", 0, 0, 5, mk(0,1,0,0,0,0,1,0,1,1,0,3));

    // I-ALU with 3 fetch waits, ready on the last tolerated cycle
    i_opcode = 7'b0010011;
    for (int i = 0; i < 3; i++) cyc("ia.fw", 0, 0, 1, f_wait);
    cyc("ia.f", 1, 0, 1, f_rdy);
    cyc("ia.d", 0, 0, 2, 0);
    cyc("ia.e", 0, 0, 3, mk(0,0,0,0,0,0,0,0,0,1,2,0));
    cyc("ia.w", 0, 0, 5, mk(0,1,0,0,0,0,1,0,0,1,2,0));
`ifdef MC_INSTRET_EN
    #1 chk("instret10", o_instret, 10);
`endif

    // Illegal opcode: sticky trap, cleared by reset
    i_opcode = 7'b1111111;
    cyc("ill.f", 1, 0, 1, f_rdy);
    cyc("ill.d", 0, 0, 2, 0);
    for (int i = 0; i < 20; i++) begin
      #1 chk("ill.trap", 32'({o_trap, o_trap_cause}), 32'({1'b1, 2'd1}));
      cyc("ill.t", 1, 0, 6, 0);
    end
    i_rst = 1'b0;
    #1;
    chk("ill.rst", 32'({o_state, o_trap, o_trap_cause}), 0);
    @(negedge clk);
    i_rst = 1'b1;

    // Reset asserted in WB aborts the write-back immediately
    i_opcode = 7'b0110011;
    cyc("ab.i", 1, 0, 0, 0);
    cyc("ab.f", 1, 0, 1, f_rdy);
    cyc("ab.d", 0, 0, 2, 0);
    cyc("ab.e", 0, 0, 3, mk(0,0,0,0,0,0,0,0,0,0,2,0));
    #1 chk("ab.wb", 32'({o_state, o_rf_we, o_pc_we}), 32'({3'd5, 2'b11}));
    i_rst = 1'b0;
    #1;
    chk("ab.rst", 32'({o_state, o_rf_we, o_pc_we}), 0);
`ifdef MC_INSTRET_EN
    chk("ab.instret", o_instret, 0);
`endif
    @(negedge clk);
    i_rst = 1'b1;

    // Fetch timeout: 3 request cycles, 4th is the suppressed timeout cycle, then TRAP
    cyc("to.i", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("to.fw", 0, 0, 1, f_wait);
    cyc("to.last", 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("to.trap", 32'({o_trap, o_trap_cause}), 32'({1'b1, 2'd2}));
      cyc("to.t", 1, 0, 6, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the RV32I core. It drives the instruction register load enable (`i_we` of the IR/decoder), PC update, memory request, register-file write and datapath mux selects. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB according to the opcode decoded by the IR. It sits between the IR/decoder, the memory port and the ALU/register-file datapath, and owns the only memory handshake in the core.

## Interface
- `WAIT_MAX`, 15: memory-wait cycles tolerated before a bus-error trap (1..255).
- `clk` in 1: sole clock, rising edge.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_opcode` in 7: opcode from IR decoder.
- `i_mem_ready` in 1: memory completes the current request this cycle.
- `i_br_taken` in 1: branch condition from the ALU compare, valid in EXEC.
- `o_ir_we` out 1: IR load enable.
- `o_pc_we` out 1: PC write.
- `o_pc_sel` out 2: 0=PC+4, 1=PC+imm (branch/JAL), 2=ALU result (JALR).
- `o_mem_req` out 1: memory request.
- `o_mem_we` out 1: store.
- `o_mem_addr_sel` out 1: 0=PC, 1=ALU result.
- `o_rf_we` out 1: register-file write.
- `o_wb_sel` out 2: 0=ALU, 1=mem data, 2=old PC+4, 3=imm (LUI).
- `o_alu_a_sel` out 1: 0=rs1, 1=old PC.
- `o_alu_b_sel` out 1: 0=rs2, 1=imm.
- `o_alu_op` out 2: 0=add, 1=branch compare (funct3), 2=funct decode.
- `o_imm_sel` out 3: 0=I, 1=S, 2=B, 3=U, 4=J.
- `o_trap` out 1: sticky trap flag.
- `o_trap_cause` out 2: 1=illegal opcode, 2=bus timeout.
- `o_state` out 3: current state for debug.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- `i_rst` low forces IDLE asynchronously and clears the wait counter, trap flag and cause.
- IDLE holds all outputs at 0 and moves to FETCH on the first clock edge after reset release.
- FETCH:
  - Drives `o_mem_req`=1 and `o_mem_addr_sel`=0.
  - In the cycle `i_mem_ready`=1, drives `o_ir_we`=1 and moves to DECODE.
- DECODE:
  - Classifies `i_opcode`. Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111 and 0010111.
  - Any other opcode goes to TRAP with cause 1. A legal opcode goes to EXEC.
  - IR is not written after FETCH, so `i_opcode` stays stable for the whole instruction.
- EXEC, per opcode class:
  - R: `a_sel`=0, `b_sel`=0, `alu_op`=2.
  - I-ALU: `b_sel`=1, `imm_sel`=0, `alu_op`=2.
  - LOAD: `b_sel`=1, `imm_sel`=0, `alu_op`=0.
  - STORE: `b_sel`=1, `imm_sel`=1, `alu_op`=0.
  - AUIPC: `a_sel`=1, `b_sel`=1, `imm_sel`=3, `alu_op`=0.
  - LUI: `imm_sel`=3.
  - JAL: `imm_sel`=4.
  - JALR: `b_sel`=1, `imm_sel`=0, `alu_op`=0.
  - BRANCH: `alu_op`=1, `imm_sel`=2. Drives `o_pc_we`=1 with `pc_sel`=`i_br_taken`?1:0, then goes to FETCH.
- After EXEC: LOAD and STORE go to MEM; all other non-branch classes go to WB.
- MEM:
  - Drives `o_mem_req`=1, `o_mem_addr_sel`=1, and `o_mem_we`=1 for STORE.
  - On `i_mem_ready`, LOAD goes to WB. STORE drives `o_pc_we`=1 with `pc_sel`=0 and goes to FETCH.
- WB:
  - Drives `o_rf_we`=1 and `o_pc_we`=1, then goes to FETCH.
  - `wb_sel`: 0 for R/I-ALU/AUIPC, 1 for LOAD, 2 for JAL/JALR, 3 for LUI.
  - `pc_sel`: 1 for JAL, 2 for JALR, 0 otherwise.
- `o_pc_we` pulses exactly once per retired instruction.
- Wait counter (8-bit):
  - Counts cycles in FETCH/MEM with `i_mem_ready`=0 and clears on state change.
  - Reaching `WAIT_MAX` goes to TRAP with cause 2 and suppresses all side effects in that cycle.
- TRAP: all control outputs 0, `o_trap`=1, cause held; exited only by reset.
- Outputs are combinational from the state register and `i_opcode`/`i_br_taken`/`i_mem_ready`. They are glitch-free relative to `clk` because those inputs are registered upstream.

## Timing
- Reset values: every output 0 and `o_state`=0.
- Latency with zero-wait memory (`i_mem_ready`=1 in the first request cycle):
  - Branch: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- `o_mem_req` stays high until the `i_mem_ready` cycle inclusive and drops the cycle after.
- `i_mem_ready` is ignored outside FETCH/MEM.
- `i_mem_ready`=1 in the same cycle the counter hits `WAIT_MAX`: ready wins and there is no trap.
- Reset asserted mid-instruction aborts the instruction: no PC/RF write after the asynchronous assertion.

## Configuration
- `MC_INSTRET_EN` defined:
  - Adds output `o_instret` [31:0], reset 0.
  - Increments on each `o_pc_we` pulse and wraps from 0xFFFFFFFF to 0.
- `MC_INSTRET_EN` undefined: the port and the counter are absent.

## Test plan
- Reset held low 2 cycles, released: all outputs 0, `o_state`=0, then 1 on the first edge with `o_mem_req`=1.
- Opcode 0110011 with immediate ready: states 1→2→3→5→1; `o_rf_we`=1, `o_pc_we`=1, `pc_sel`=0 in WB only; 4 cycles total.
- Opcode 0000011 with `i_mem_ready` delayed 3 cycles in MEM: `o_mem_req`=1 and `o_mem_addr_sel`=1 for 4 cycles, then WB with `wb_sel`=1.
- Opcode 1100011 with `i_br_taken`=1 then another with 0: EXEC gives `o_pc_we`=1 with `pc_sel`=1, then `pc_sel`=0; no `o_rf_we`.
- Opcode 1111111: TRAP, `o_trap`=1, `o_trap_cause`=1, sticky for 20 cycles; reset clears.
- `WAIT_MAX`=4 and `i_mem_ready` held 0 in FETCH: after 4 cycles TRAP with cause 2 and no `o_ir_we`. With `MC_INSTRET_EN`, `o_instret` counts 3 after three ALU instructions.
